// File: rtl/cpu_state_ctrl.sv
// Multi-cycle sequencer for the MIPS core: drives the datapath state bus,
// Avalon-style memory strobes, PC write enable and the retired-instruction count.
module cpu_state_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             waitrequest,
  input  logic             instr_is_load,
  input  logic             instr_is_store,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             active,
  output logic             read,
  output logic             write,
  output logic             addr_sel,
  output logic             pc_we,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_EXEC1 = 3'd2;
  localparam logic [2:0] S_EXEC2 = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;
  localparam logic [2:0] S_IDLE  = 3'd5;

  logic [2:0] next_state;
  logic       is_mem;
  logic       ld_st_conflict;

  assign is_mem         = instr_is_load | instr_is_store;
  assign ld_st_conflict = instr_is_load & instr_is_store;

  // Memory handshake: a request (read or write) is held unchanged while
  // waitrequest is high; it completes on the first rising edge that sees
  // waitrequest low. Strobes are pure decodes of state and the decoded IR.
  always_comb begin
    read     = 1'b0;
    write    = 1'b0;
    addr_sel = 1'b0;
    pc_we    = 1'b0;
    case (state)
      S_FETCH: read = 1'b1;
      S_EXEC1: pc_we = ~is_mem;
      S_EXEC2: begin
        read     = instr_is_load & ~instr_is_store;
        write    = instr_is_store & ~instr_is_load;
        addr_sel = 1'b1;
        pc_we    = ~waitrequest;
      end
      default: ;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_FETCH;
      S_FETCH: next_state = waitrequest ? S_FETCH : S_LOAD;
      S_LOAD:  next_state = S_EXEC1;
      S_EXEC1: begin
        if (ld_st_conflict)
          next_state = S_HALT;
        else if (is_mem)
          next_state = S_EXEC2;
        else
          next_state = halt_req ? S_HALT : S_FETCH;
      end
      S_EXEC2: begin
        if (!waitrequest)
          next_state = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      // Encodings 6 and 7 are unreachable; recover into HALT.
      default: next_state = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      active  <= 1'b0;
      retired <= '0;
    end else begin
      state  <= next_state;
      active <= (next_state != S_HALT) && (next_state != S_IDLE);
      if (pc_we)
        retired <= retired + CNT_W'(1);
    end
  end

endmodule
